// File: rtl/ysyx_22040127_idu_stage_if.sv
// IFU->IDU->EXU handshake bundle for the decode stage: fetch side (in_*) and decoded side (out_*).
interface ysyx_22040127_idu_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_type;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic            out_reg_wen;
  logic            out_memread;
  logic            out_memwrite;
  logic            out_word;
  logic            out_ebreak;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_type, out_imm,
           out_funct3, out_funct7b5, out_reg_wen, out_memread, out_memwrite, out_word,
           out_ebreak, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_type, out_imm,
           out_funct3, out_funct7b5, out_reg_wen, out_memread, out_memwrite, out_word,
           out_ebreak, out_illegal
  );
endinterface

// File: rtl/ysyx_22040127_idu_stage.sv
// RV32/RV64 decode stage: combinational decode captured into a 2-entry skid buffer so that
// in_ready is purely registered and never depends on out_ready.
module ysyx_22040127_idu_stage #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned RV64_OPS = 1
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  input logic                         i_flush,
  ysyx_22040127_idu_stage_if.slave    io_idu
);
  localparam bit WOk = (RV64_OPS != 0) && (XLEN == 64);

  localparam logic [2:0] TyI = 3'd0, TyU = 3'd1, TyS = 3'd2, TyJ = 3'd3;
  localparam logic [2:0] TyR = 3'd4, TyB = 3'd5, TyN = 3'd6, TyX = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      typ;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_wen;
    logic            memread;
    logic            memwrite;
    logic            word;
    logic            ebreak;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  entry_t      r_main;
  entry_t      r_skid;
  entry_t      w_dec;
  logic [31:0] w_inst;
  logic [6:0]  w_op;
  logic [2:0]  w_typ;
  logic [63:0] w_imm64;
  logic        w_accept;
  logic        w_retire;

  assign w_inst   = io_idu.in_inst;
  assign w_op     = w_inst[6:0];
  assign w_accept = io_idu.in_valid & r_in_ready;
  assign w_retire = r_out_valid & io_idu.out_ready;

  always_comb begin
    w_typ = TyX;
    case (w_op)
      7'b0110111, 7'b0010111:            w_typ = TyU;
      7'b0010011, 7'b0000011, 7'b1100111: w_typ = TyI;
      7'b0011011:                        w_typ = WOk ? TyI : TyX;
      7'b1101111:                        w_typ = TyJ;
      7'b0110011:                        w_typ = TyR;
      7'b0111011:                        w_typ = WOk ? TyR : TyX;
      7'b0100011:                        w_typ = TyS;
      7'b1100011:                        w_typ = TyB;
      7'b1110011:                        w_typ = TyN;
      default:                           w_typ = TyX;
    endcase
  end

  // Immediates are built at 64 bits and truncated, so XLEN=32 needs no special casing.
  always_comb begin
    w_imm64 = '0;
    case (w_typ)
      TyI, TyN: w_imm64 = {{52{w_inst[31]}}, w_inst[31:20]};
      TyS:      w_imm64 = {{52{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      TyB:      w_imm64 = {{51{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                           w_inst[11:8], 1'b0};
      TyU:      w_imm64 = {{32{w_inst[31]}}, w_inst[31:12], 12'b0};
      TyJ:      w_imm64 = {{43{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                           w_inst[30:21], 1'b0};
      default:  w_imm64 = '0;
    endcase
  end

  always_comb begin
    w_dec          = '0;
    w_dec.pc       = io_idu.in_pc;
    w_dec.rd       = w_inst[11:7];
    w_dec.rs1      = w_inst[19:15];
    w_dec.rs2      = w_inst[24:20];
    w_dec.typ      = w_typ;
    w_dec.imm      = w_imm64[XLEN-1:0];
    w_dec.funct3   = w_inst[14:12];
    w_dec.funct7b5 = w_inst[30];
    w_dec.reg_wen  = (w_typ == TyI || w_typ == TyU || w_typ == TyJ || w_typ == TyR) &&
                     (w_inst[11:7] != 5'd0);
    w_dec.memread  = (w_op == 7'b0000011) && (w_typ != TyX);
    w_dec.memwrite = (w_op == 7'b0100011) && (w_typ != TyX);
    w_dec.word     = (w_op == 7'b0011011) || (w_op == 7'b0111011);
    w_dec.ebreak   = (w_inst == 32'h0010_0073);
    w_dec.illegal  = (w_typ == TyX);
  end

  // Flush wins over accept/retire; a retire in the flush cycle is still visible to EXU.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StEmpty;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (i_flush) begin
      r_state     <= StEmpty;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_main      <= w_dec;
            r_state     <= StOne;
            r_out_valid <= 1'b1;
          end
        end
        StOne: begin
          if (w_accept && w_retire) begin
            r_main <= w_dec;
          end else if (w_accept) begin
            r_skid     <= w_dec;
            r_state    <= StTwo;
            r_in_ready <= 1'b0;
          end else if (w_retire) begin
            r_state     <= StEmpty;
            r_out_valid <= 1'b0;
          end
        end
        StTwo: begin
          if (w_retire) begin
            r_main     <= r_skid;
            r_state    <= StOne;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_idu.in_ready     = r_in_ready;
  assign io_idu.out_valid    = r_out_valid;
  assign io_idu.out_pc       = r_main.pc;
  assign io_idu.out_rd       = r_main.rd;
  assign io_idu.out_rs1      = r_main.rs1;
  assign io_idu.out_rs2      = r_main.rs2;
  assign io_idu.out_type     = r_main.typ;
  assign io_idu.out_imm      = r_main.imm;
  assign io_idu.out_funct3   = r_main.funct3;
  assign io_idu.out_funct7b5 = r_main.funct7b5;
  assign io_idu.out_reg_wen  = r_main.reg_wen;
  assign io_idu.out_memread  = r_main.memread;
  assign io_idu.out_memwrite = r_main.memwrite;
  assign io_idu.out_word     = r_main.word;
  assign io_idu.out_ebreak   = r_main.ebreak;
  assign io_idu.out_illegal  = r_main.illegal;
endmodule
